connect_four_move_arbiter: RTL and testbench
============================================

Name: connect_four_move_arbiter

Overview:
- Sits between the move sources and connect_four_datapath, and sequences each move through the datapath's strobe interface.
- Two sources exist: the human cursor/drop path and a CPU opponent engine.
- The block selects the source that owns the current turn, latches its column, and runs validate → find-row → drop → evaluate → switch-player.
- It reports accept/reject to the requester and holds the game-over status.

Parameters:
- COL_W, 3, width of a column index; 8 columns.
- CPU_TIMEOUT, 64, number of tick pulses the CPU may stay silent on its turn before the human port may move for it.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > CPU_TIMEOUT.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  player assignment: 00 human vs human, 01 CPU is P2, 10 CPU is P1, 11 CPU vs CPU.
- tick  in  1  one-cycle pacing pulse, used only by the timeout counter.
- new_game  in  1  one-cycle pulse; aborts any move and clears the board.
- h_req  in  1  human move request; level, held until h_ack or h_nak.
- h_col  in  COL_W  human column; stable while h_req is high.
- h_ack  out  1  one-cycle pulse: human move committed.
- h_nak  out  1  one-cycle pulse: human move rejected because the column is full.
- c_req  in  1  CPU move request; same rules as h_req.
- c_col  in  COL_W  CPU column.
- c_ack  out  1  one-cycle pulse: CPU move committed.
- c_nak  out  1  one-cycle pulse: CPU move rejected.
- current_player  in  2  from the datapath: 01 = P1, 10 = P2.
- column_full  in  1  datapath status; valid the cycle after validate_enable.
- win_found  in  1  datapath status; valid two cycles after drop_token.
- board_full  in  1  datapath status; valid two cycles after drop_token.
- cursor_col  out  COL_W  latched column driven to the datapath.
- clear_board  out  1  strobe to the datapath.
- validate_enable  out  1  strobe to the datapath.
- find_row_enable  out  1  strobe to the datapath.
- drop_token  out  1  strobe to the datapath.
- switch_player_enable  out  1  strobe to the datapath.
- winner_enable  out  1  terminal flag: win or draw.
- winner_player  out  2  01 = P1 wins, 10 = P2 wins, 00 = draw.
- cpu_timeout  out  1  sticky flag: the human port took a CPU turn.
- busy  out  1  high in every state except IDLE and OVER.

Behaviour:
- All outputs are registered; all strobes are single-cycle.
- Reset values: state=CLEAR; cursor_col=0; strobes, acks and naks=0; winner_enable=0; winner_player=00; cpu_timeout=0; timeout counter=0.
- Turn owner is decoded from mode and current_player. For mode 11, both players are CPU. For mode 00, both players are human.
- FSM states and transitions:
  - CLEAR: clear_board=1 for one cycle, winner flags cleared → IDLE. This is the first state after reset release.
  - IDLE: if the owner's req is high, latch its col into cursor_col, record the granted source, → VALIDATE. The non-owner's req is ignored and left pending, with no ack/nak. mode is sampled only in IDLE.
  - VALIDATE: validate_enable=1 → VWAIT.
  - VWAIT: if column_full=1, pulse the granted source's nak → IDLE. Otherwise → FIND.
  - FIND: find_row_enable=1 → DROP.
  - DROP: drop_token=1 → SETTLE.
  - SETTLE: one wait cycle → EVAL.
  - EVAL, checked in priority order:
    - win_found=1: winner_player=current_player, winner_enable=1, ack → OVER.
    - else board_full=1: winner_player=00, winner_enable=1, ack → OVER.
    - else → SWITCH.
  - SWITCH: switch_player_enable=1, ack → IDLE.
  - OVER: all reqs are ignored; winner outputs hold; leave only via new_game.
- Accepted-move latency: 7 cycles from the IDLE grant to the ack (VALIDATE..SWITCH). Rejected-move latency: nak on the 3rd cycle after the grant.
- new_game in any state, including mid-move, → CLEAR next cycle. The in-flight move gets no ack/nak, and the timeout counter clears.
- Timeout counter:
  - Counts tick pulses only while in IDLE, the owner is CPU, and c_req=0.
  - Clears on any grant, on a change of owner, or on new_game.
  - When the count reaches CPU_TIMEOUT, the human port is additionally accepted as the owner for this turn, and cpu_timeout is set sticky; only reset or new_game clears it.
  - If c_req and h_req are both high in that window, c_req wins.
  - The counter saturates at CPU_TIMEOUT.
- Simultaneous h_req/c_req with a single owner: only the owner is served. Out-of-range columns are impossible with 8 columns (full COL_W range is valid).

Test Plan:
- Reset release with mode=00: clear_board pulses on the 1st cycle. h_req with h_col=3, column_full=0, win/full=0 → validate, find, drop, switch on consecutive strobe states; cursor_col=3; h_ack 7 cycles after the grant.
- Full column: mode=00, column_full=1 after validate → h_nak on the 3rd cycle; no drop_token and no switch_player_enable; return to IDLE.
- mode=01 with current_player=10, both h_req and c_req high (c_col=5) → c_ack; h_req stays pending with no h_ack/h_nak; cursor_col=5.
- Win: win_found=1 in EVAL with current_player=01 → winner_enable=1, winner_player=01, ack pulsed, no switch strobe. Further reqs are ignored. new_game → clear_board, winner_enable=0.
- Draw plus mid-move abort:
  - board_full=1, win_found=0 → winner_player=00.
  - Separately, new_game asserted during DROP → CLEAR next cycle with no ack.
- Timeout with CPU_TIMEOUT=4: mode=01, P2's turn, c_req=0. After 4 ticks, h_req (h_col=2) is accepted and cpu_timeout=1. After the next new_game, cpu_timeout=0.

Source files
------------

// File: rtl/connect_four_move_arbiter.sv
// Move arbiter for the Connect Four datapath: serves the turn owner's request,
// sequences it through the datapath strobes and holds the game-over result.
module connect_four_move_arbiter #(
  parameter int COL_W       = 3,
  parameter int CPU_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             tick,
  input  logic             new_game,
  input  logic             h_req,
  input  logic [COL_W-1:0] h_col,
  output logic             h_ack,
  output logic             h_nak,
  input  logic             c_req,
  input  logic [COL_W-1:0] c_col,
  output logic             c_ack,
  output logic             c_nak,
  input  logic [1:0]       current_player,
  input  logic             column_full,
  input  logic             win_found,
  input  logic             board_full,
  output logic [COL_W-1:0] cursor_col,
  output logic             clear_board,
  output logic             validate_enable,
  output logic             find_row_enable,
  output logic             drop_token,
  output logic             switch_player_enable,
  output logic             winner_enable,
  output logic [1:0]       winner_player,
  output logic             cpu_timeout,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_VALIDATE, S_VWAIT, S_FIND,
    S_DROP, S_SETTLE, S_EVAL, S_SWITCH, S_OVER
  } state_e;

  localparam logic [1:0]      P1     = 2'b01;
  localparam logic [1:0]      P2     = 2'b10;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(CPU_TIMEOUT);

  state_e           state_q, state_d;
  logic             src_cpu_q, src_cpu_d;
  logic [COL_W-1:0] col_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [2:0]       owner_q, owner_d;
  logic             win_en_d, cpu_to_d;
  logic [1:0]       win_pl_d;
  logic             ack_d, nak_d;
  logic             cpu_turn, to_expired, grant_c, grant_h;

  // The human port may stand in for a silent CPU once the timeout expires.
  always_comb begin
    cpu_turn   = (mode[0] && current_player == P2) || (mode[1] && current_player == P1);
    to_expired = (to_q == TO_MAX);
    grant_c    = cpu_turn && c_req;
    grant_h    = !grant_c && h_req && (!cpu_turn || to_expired);
  end

  // NOTE: every signal gets its hold/default value first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    src_cpu_d = src_cpu_q;
    col_d     = cursor_col;
    to_d      = to_q;
    owner_d   = {cpu_turn, current_player};
    win_en_d  = winner_enable;
    win_pl_d  = winner_player;
    cpu_to_d  = cpu_timeout;
    ack_d     = 1'b0;
    nak_d     = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        state_d  = S_IDLE;
        win_en_d = 1'b0;
        win_pl_d = 2'b00;
      end
      S_IDLE: begin
        if (grant_c || grant_h) begin
          state_d   = S_VALIDATE;
          src_cpu_d = grant_c;
          col_d     = grant_c ? c_col : h_col;
          to_d      = '0;
          if (grant_h && cpu_turn) cpu_to_d = 1'b1;
        end else if (owner_d != owner_q) begin
          to_d = '0;
        end else if (cpu_turn && !c_req && tick && !to_expired) begin
          to_d = to_q + 1'b1;
        end
      end
      S_VALIDATE: state_d = S_VWAIT;
      S_VWAIT: begin
        if (column_full) begin
          nak_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_FIND;
        end
      end
      S_FIND:   state_d = S_DROP;
      S_DROP:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_EVAL;
      S_EVAL: begin
        ack_d = 1'b1;
        if (win_found) begin
          win_en_d = 1'b1;
          win_pl_d = current_player;
          state_d  = S_OVER;
        end else if (board_full) begin
          win_en_d = 1'b1;
          win_pl_d = 2'b00;
          state_d  = S_OVER;
        end else begin
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: state_d = S_IDLE;
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_CLEAR;
    endcase

    // A new game abandons the in-flight move silently.
    if (new_game) begin
      state_d  = S_CLEAR;
      ack_d    = 1'b0;
      nak_d    = 1'b0;
      to_d     = '0;
      cpu_to_d = 1'b0;
      win_en_d = 1'b0;
      win_pl_d = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= S_CLEAR;
      src_cpu_q            <= 1'b0;
      to_q                 <= '0;
      owner_q              <= '0;
      cursor_col           <= '0;
      clear_board          <= 1'b0;
      validate_enable      <= 1'b0;
      find_row_enable      <= 1'b0;
      drop_token           <= 1'b0;
      switch_player_enable <= 1'b0;
      h_ack                <= 1'b0;
      h_nak                <= 1'b0;
      c_ack                <= 1'b0;
      c_nak                <= 1'b0;
      winner_enable        <= 1'b0;
      winner_player        <= 2'b00;
      cpu_timeout          <= 1'b0;
      busy                 <= 1'b1;
    end else begin
      state_q              <= state_d;
      src_cpu_q            <= src_cpu_d;
      to_q                 <= to_d;
      owner_q              <= owner_d;
      cursor_col           <= col_d;
      clear_board          <= (state_q == S_CLEAR);
      validate_enable      <= (state_d == S_VALIDATE);
      find_row_enable      <= (state_d == S_FIND);
      drop_token           <= (state_d == S_DROP);
      switch_player_enable <= (state_d == S_SWITCH);
      h_ack                <= ack_d && !src_cpu_q;
      h_nak                <= nak_d && !src_cpu_q;
      c_ack                <= ack_d && src_cpu_q;
      c_nak                <= nak_d && src_cpu_q;
      winner_enable        <= win_en_d;
      winner_player        <= win_pl_d;
      cpu_timeout          <= cpu_to_d;
      busy                 <= !(state_d inside {S_IDLE, S_OVER});
    end
  end

endmodule

// File: tb/tb_connect_four_move_arbiter.sv
// Self-checking bench: emulates the datapath and predicts each move outcome
// from the game rules (column heights, whose turn, who may move).
module tb_connect_four_move_arbiter;
  localparam int ROWS = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       tick = 1'b0, new_game = 1'b0;
  logic       h_req = 1'b0, c_req = 1'b0;
  logic [2:0] h_col = '0, c_col = '0;
  logic       h_ack, h_nak, c_ack, c_nak;
  logic [1:0] dp_cp;
  logic       column_full;
  logic       f_win = 1'b0, f_full = 1'b0;
  logic [2:0] cursor_col;
  logic       clear_board, validate_enable, find_row_enable, drop_token;
  logic       switch_player_enable, winner_enable, cpu_timeout, busy;
  logic [1:0] winner_player;

  int checks = 0;
  int errors = 0;

  // Reference game state.
  int         m_h [8];
  logic [1:0] m_cp;
  bit         m_over, m_cpu_to;
  logic [1:0] m_winner;

  // Datapath emulation driven by the DUT strobes.
  logic [3:0] dp_h [8];

  connect_four_move_arbiter #(.COL_W(3), .CPU_TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .tick(tick), .new_game(new_game),
    .h_req(h_req), .h_col(h_col), .h_ack(h_ack), .h_nak(h_nak),
    .c_req(c_req), .c_col(c_col), .c_ack(c_ack), .c_nak(c_nak),
    .current_player(dp_cp), .column_full(column_full),
    .win_found(f_win), .board_full(f_full),
    .cursor_col(cursor_col), .clear_board(clear_board),
    .validate_enable(validate_enable), .find_row_enable(find_row_enable),
    .drop_token(drop_token), .switch_player_enable(switch_player_enable),
    .winner_enable(winner_enable), .winner_player(winner_player),
    .cpu_timeout(cpu_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  assign column_full = (dp_h[cursor_col] >= 4'(ROWS));

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear_board) begin
      for (int i = 0; i < 8; i++) dp_h[i] <= '0;
      dp_cp <= 2'b01;
    end else begin
      if (drop_token) dp_h[cursor_col] <= dp_h[cursor_col] + 4'd1;
      if (switch_player_enable) dp_cp <= (dp_cp == 2'b01) ? 2'b10 : 2'b01;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_h[i] = 0;
    m_cp = 2'b01; m_over = 0; m_cpu_to = 0; m_winner = 2'b00;
  endtask

  // Observe one granted move; the first step is the grant edge.
  task automatic watch_move(input int src, input int col, input bit w, input bit f);
    int  ack_c = 0, nak_c = 0, other = 0, drops = 0, sws = 0;
    int  val_c = 0, find_c = 0, drop_c = 0, sw_c = 0;
    int  cur1 = 0;
    bit  exp_nak = (m_h[col] >= ROWS);
    bit  s_ack, s_nak, o_any;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step();
      s_ack = (src == 2) ? c_ack : h_ack;
      s_nak = (src == 2) ? c_nak : h_nak;
      o_any = (src == 2) ? (h_ack | h_nak) : (c_ack | c_nak);
      if (cyc == 1) cur1 = int'(cursor_col);
      if (s_ack && ack_c == 0) ack_c = cyc;
      if (s_nak && nak_c == 0) nak_c = cyc;
      if (s_ack || s_nak) begin h_req = 1'b0; c_req = 1'b0; end
      if (o_any) other++;
      if (validate_enable) val_c = cyc;
      if (find_row_enable) find_c = cyc;
      if (drop_token) begin drop_c = cyc; drops++; end
      if (switch_player_enable) begin sw_c = cyc; sws++; end
    end
    h_req = 1'b0; c_req = 1'b0;
    check("cursor_col", cur1, col);
    check("other_src_quiet", other, 0);
    if (exp_nak) begin
      check("nak_cycle", nak_c, 3);
      check("ack_none", ack_c, 0);
      check("no_drop_on_nak", drops, 0);
      check("no_switch_on_nak", sws, 0);
    end else begin
      check("ack_cycle", ack_c, 7);
      check("nak_none", nak_c, 0);
      check("validate_cycle", val_c, 1);
      check("find_cycle", find_c, 3);
      check("drop_cycle", drop_c, 4);
      if (w || f) check("no_switch_terminal", sws, 0);
      else        check("switch_cycle", sw_c, 7);
      m_h[col]++;
      if (w)      begin m_over = 1; m_winner = m_cp; end
      else if (f) begin m_over = 1; m_winner = 2'b00; end
      else        m_cp = (m_cp == 2'b01) ? 2'b10 : 2'b01;
    end
    check("winner_enable", winner_enable, m_over);
    if (m_over) check("winner_player", winner_player, m_winner);
    check("cpu_timeout_flag", cpu_timeout, m_cpu_to);
  endtask

  task automatic do_move(input bit hr, input bit cr, input int hc, input int cc,
                         input bit w, input bit f);
    bit cpu_own = (mode[0] && m_cp == 2'b10) || (mode[1] && m_cp == 2'b01);
    int src = cpu_own ? (cr ? 2 : 0) : (hr ? 1 : 0);
    int cnt = 0;
    h_req = hr; c_req = cr; h_col = 3'(hc); c_col = 3'(cc);
    f_win = w; f_full = f;
    if (src == 0) begin
      repeat (8) begin
        step();
        if (h_ack | h_nak | c_ack | c_nak | busy) cnt++;
      end
      h_req = 1'b0; c_req = 1'b0;
      check("non_owner_ignored", cnt, 0);
    end else begin
      watch_move(src, (src == 2) ? cc : hc, w, f);
    end
  endtask

  task automatic new_game_pulse();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("busy_in_clear", busy, 1);
    check("cpu_timeout_cleared", cpu_timeout, 0);
    step();
    check("clear_board_pulse", clear_board, 1);
    check("winner_cleared", winner_enable, 0);
    step();
    model_reset();
  endtask

  task automatic over_hold();
    int cnt = 0;
    h_req = 1'b1; c_req = 1'b1;
    repeat (8) begin
      step();
      if (h_ack | h_nak | c_ack | c_nak | busy) cnt++;
    end
    h_req = 1'b0; c_req = 1'b0;
    check("over_reqs_ignored", cnt, 0);
    check("over_winner_hold", {winner_enable, winner_player}, {1'b1, m_winner});
    new_game_pulse();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int cnt;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_clear_board", clear_board, 0);
    check("rst_cursor_col", cursor_col, 0);
    check("rst_acks", {h_ack, h_nak, c_ack, c_nak}, 0);
    check("rst_winner", {winner_enable, winner_player}, 0);
    check("rst_cpu_timeout", cpu_timeout, 0);
    reset_n = 1'b1;
    step();
    check("first_clear_board", clear_board, 1);
    step();
    check("idle_not_busy", busy, 0);
    step();

    // Basic human move, then CPU-owned turn with a competing human request.
    mode = 2'b00;
    do_move(1, 0, 3, 0, 0, 0);
    mode = 2'b01;
    do_move(1, 1, 3, 5, 0, 0);

    // Fill column 0; the seventh drop is rejected.
    mode = 2'b00;
    for (int i = 0; i < 7; i++) do_move(1, 0, 0, 0, 0, 0);

    // Win, then draw.
    do_move(1, 0, 4, 0, 1, 0);
    over_hold();
    do_move(1, 0, 6, 0, 0, 1);
    over_hold();

    // Abort during DROP.
    h_req = 1'b1; h_col = 3'd1;
    repeat (4) step();
    check("abort_at_drop", drop_token, 1);
    new_game = 1'b1;
    step();
    new_game = 1'b0; h_req = 1'b0;
    check("abort_busy_clear", busy, 1);
    cnt = 0;
    repeat (9) begin
      step();
      if (h_ack | h_nak | c_ack | c_nak) cnt++;
    end
    check("abort_no_ack", cnt, 0);
    model_reset();

    // CPU timeout: human stands in for the silent CPU after 4 ticks.
    mode = 2'b01;
    do_move(1, 0, 2, 0, 0, 0);
    h_req = 1'b1; h_col = 3'd2; c_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    check("timeout_not_yet", busy, 0);
    tick = 1'b1; step();
    tick = 1'b0;
    m_cpu_to = 1;
    watch_move(1, 2, 0, 0);
    new_game_pulse();

    // Randomized moves.
    for (int n = 0; n < 40; n++) begin
      bit hr, cr, w, f;
      int hc, cc;
      mode = 2'($urandom_range(0, 3));
      hr = 1'($urandom_range(0, 1));
      cr = 1'($urandom_range(0, 1));
      if (!hr && !cr) hr = 1;
      hc = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 7);
      cc = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 7);
      w = ($urandom_range(0, 11) == 0);
      f = ($urandom_range(0, 15) == 0);
      do_move(hr, cr, hc, cc, w, f);
      if (m_over) over_hold();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
